// File: rtl/nco_pkg.sv
// nco_pkg: shared constants and the quarter-wave ROM content function for
// the numerically controlled oscillator.
//   NCO_LATENCY   enabled clock edges from an accepted phase to tdata_o
//   LFSR_*        dither generator constants (used when NCO_DITHER_EN is set)
//   sin_rom_value quarter-wave ROM entry k, evaluated at elaboration time
package nco_pkg;

  localparam int          NCO_LATENCY = 4;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  localparam int          LFSR_WIDTH  = 16;
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;

  localparam real         NCO_PI      = 3.14159265358979323846;

  // Entry k samples the first quadrant half a step off the grid:
  // (2k+1)*pi / 2^(addr_w+2). The half-step keeps mirrored addresses (~k)
  // exact and means no entry is zero or full-scale-only, so a later
  // two's-complement negate can never overflow. All values are positive,
  // so adding 0.5 before truncation rounds to nearest.
  function automatic int sin_rom_value(input int k, input int addr_w,
                                       input int data_w);
    real amp;
    real ang;
    amp = $itor((1 << (data_w - 1)) - 1);
    ang = $itor(2 * k + 1) * NCO_PI / $itor(1 << (addr_w + 2));
    return $rtoi(amp * $sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/nco_quarter_rom.sv
// nco_quarter_rom: dual-read-port quarter-wave sine ROM with registered
// outputs. Contents come from nco_pkg::sin_rom_value at elaboration.
//   clk_i, rstn_i         clock, asynchronous active-low reset
//   en_i                  read enable; output registers hold when low
//   addr_a_i / addr_b_i   read addresses
//   data_a_o / data_b_o   registered ROM words (one cycle after address)
module nco_quarter_rom
  import nco_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [ADDR_W-1:0] addr_b_i,
  output logic [DATA_W-1:0] data_a_o,
  output logic [DATA_W-1:0] data_b_o
);

  logic [DATA_W-1:0] w_rom [2**ADDR_W];

  for (genvar k = 0; k < 2**ADDR_W; k++) begin : g_rom
    localparam int LP_VAL = sin_rom_value(k, ADDR_W, DATA_W);
    assign w_rom[k] = LP_VAL[DATA_W-1:0];
  end

  logic [DATA_W-1:0] r_data_a;
  logic [DATA_W-1:0] r_data_b;

  // The output registers clear on reset so the whole pipeline starts from 0.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_data_a <= '0;
      r_data_b <= '0;
    end else if (en_i) begin
      r_data_a <= w_rom[addr_a_i];
      r_data_b <= w_rom[addr_b_i];
    end
  end

  assign data_a_o = r_data_a;
  assign data_b_o = r_data_b;

endmodule

// File: rtl/nco.sv
// nco: numerically controlled oscillator producing {cos, sin} samples.
// Phase accumulator -> quadrant fold -> quarter-wave ROM -> sign restore.
//   clk_i, rstn_i    clock, asynchronous active-low reset
//   en_i             clock enable; every register holds when low
//   tvalid_i         phase-valid; the accumulator steps on en_i & tvalid_i
//   phase_inc_i      unsigned frequency word
//   phase_offset_i   unsigned phase offset, sampled with tvalid_i
//   tvalid_o         output sample valid
//   tdata_o          [0] = I (cos), [1] = Q (sin), signed two's complement
// Optional feature macro: NCO_DITHER_EN adds LFSR phase dither before the
// phase is truncated to the ROM address.
//
// Valid semantics: there is no ready; a sample is accepted on every clock
// edge where en_i & tvalid_i, and appears on tdata_o with tvalid_o high
// exactly NCO_LATENCY enabled edges later. Edges with en_i low do not count
// and leave every output frozen.
module nco
  import nco_pkg::*;
#(
  parameter int IQ_NUM         = 2,
  parameter int DATA_WIDTH     = 16,
  parameter int PHASE_WIDTH    = 32,
  parameter int LUT_ADDR_WIDTH = 10
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic                                en_i,
  input  logic                                tvalid_i,
  input  logic [PHASE_WIDTH-1:0]              phase_inc_i,
  input  logic [PHASE_WIDTH-1:0]              phase_offset_i,
  output logic                                tvalid_o,
  output logic [IQ_NUM-1:0][DATA_WIDTH-1:0]   tdata_o
);

  // Phase bits below the ROM address are discarded (or dithered).
  localparam int TRUNC_LSB = PHASE_WIDTH - LUT_ADDR_WIDTH - 2;

  logic w_accept;
  assign w_accept = en_i & tvalid_i;

  // ---------------- Stage 1: phase accumulator ----------------
  // The offset is added to the pre-increment accumulator, so the first
  // sample after reset has phase = offset. Frequency changes only alter the
  // step size and therefore keep phase continuous.
  logic [PHASE_WIDTH-1:0] r_acc;
  logic [PHASE_WIDTH-1:0] r_phase;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_acc   <= '0;
      r_phase <= '0;
    end else if (w_accept) begin
      r_phase <= r_acc + phase_offset_i;
      r_acc   <= r_acc + phase_inc_i;
    end
  end

  // ---------------- Optional phase dither ----------------
  logic [PHASE_WIDTH-1:0] w_phase;

`ifdef NCO_DITHER_EN
  logic [LFSR_WIDTH-1:0]  r_lfsr;
  logic [PHASE_WIDTH-1:0] w_dither;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_accept) begin
      r_lfsr <= {1'b0, r_lfsr[LFSR_WIDTH-1:1]} ^ (r_lfsr[0] ? LFSR_TAPS : '0);
    end
  end

  // Align the LFSR MSB one bit below the truncation LSB.
  if (TRUNC_LSB >= LFSR_WIDTH) begin : g_dither_shl
    assign w_dither = PHASE_WIDTH'(r_lfsr) << (TRUNC_LSB - LFSR_WIDTH);
  end else begin : g_dither_shr
    assign w_dither = PHASE_WIDTH'(r_lfsr >> (LFSR_WIDTH - TRUNC_LSB));
  end

  assign w_phase = r_phase + w_dither;
`else
  assign w_phase = r_phase;
`endif

  if (TRUNC_LSB > 0) begin : g_trunc
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^w_phase[TRUNC_LSB-1:0];
  end

  // ---------------- Stage 2: quadrant fold ----------------
  // Odd quadrants run the quarter wave backwards (~idx); quadrants 2 and 3
  // are negative. cos(x) = sin(x + 90 deg), i.e. the sin rule on q+1.
  logic [1:0]                w_quad;
  logic [1:0]                w_cquad;
  logic [LUT_ADDR_WIDTH-1:0] w_idx;

  assign w_quad  = w_phase[PHASE_WIDTH-1 -: 2];
  assign w_cquad = w_quad + 2'd1;
  assign w_idx   = w_phase[PHASE_WIDTH-3 -: LUT_ADDR_WIDTH];

  logic [LUT_ADDR_WIDTH-1:0] r_sin_addr;
  logic [LUT_ADDR_WIDTH-1:0] r_cos_addr;
  logic                      r_sin_neg_s2;
  logic                      r_cos_neg_s2;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sin_addr   <= '0;
      r_cos_addr   <= '0;
      r_sin_neg_s2 <= 1'b0;
      r_cos_neg_s2 <= 1'b0;
    end else if (en_i) begin
      r_sin_addr   <= w_quad[0]  ? ~w_idx : w_idx;
      r_cos_addr   <= w_cquad[0] ? ~w_idx : w_idx;
      r_sin_neg_s2 <= w_quad[1];
      r_cos_neg_s2 <= w_cquad[1];
    end
  end

  // ---------------- Stage 3: ROM read ----------------
  logic [DATA_WIDTH-1:0] w_rom_sin;
  logic [DATA_WIDTH-1:0] w_rom_cos;

  nco_quarter_rom #(
    .ADDR_W (LUT_ADDR_WIDTH),
    .DATA_W (DATA_WIDTH)
  ) u_rom (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .en_i     (en_i),
    .addr_a_i (r_sin_addr),
    .addr_b_i (r_cos_addr),
    .data_a_o (w_rom_sin),
    .data_b_o (w_rom_cos)
  );

  // Sign flags travel alongside the ROM read so they line up with its data.
  logic r_sin_neg_s3;
  logic r_cos_neg_s3;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sin_neg_s3 <= 1'b0;
      r_cos_neg_s3 <= 1'b0;
    end else if (en_i) begin
      r_sin_neg_s3 <= r_sin_neg_s2;
      r_cos_neg_s3 <= r_cos_neg_s2;
    end
  end

  // ---------------- Stage 4: sign restore ----------------
  logic [DATA_WIDTH-1:0] r_cos_out;
  logic [DATA_WIDTH-1:0] r_sin_out;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cos_out <= '0;
      r_sin_out <= '0;
    end else if (en_i) begin
      r_cos_out <= r_cos_neg_s3 ? -w_rom_cos : w_rom_cos;
      r_sin_out <= r_sin_neg_s3 ? -w_rom_sin : w_rom_sin;
    end
  end

  // ---------------- Valid pipe ----------------
  // Bubbles (tvalid_i low with en_i high) flow through as zeros while the
  // data stages keep advancing.
  logic [NCO_LATENCY-1:0] r_vpipe;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_vpipe <= '0;
    end else if (en_i) begin
      r_vpipe <= {r_vpipe[NCO_LATENCY-2:0], tvalid_i};
    end
  end

  assign tvalid_o   = r_vpipe[NCO_LATENCY-1];
  assign tdata_o[0] = r_cos_out;
  assign tdata_o[1] = r_sin_out;

endmodule

// File: tb/tb_nco.sv
module tb_nco;

  localparam int DW = 16;
  localparam int PW = 32;
  localparam int AW = 10;
  // Scoreboard entry: {valid, issue_edge[31:0], I[DW-1:0], Q[DW-1:0]}
  localparam int W  = 1 + 32 + 2 * DW;
  localparam real PI = 3.14159265358979323846;

  // ---------------- Clock / reset ----------------
  logic clk    = 1'b0;
  logic rstn_i = 1'b1;
  logic en_i   = 1'b0;
  logic tvalid_i = 1'b0;
  logic [PW-1:0] phase_inc_i    = '0;
  logic [PW-1:0] phase_offset_i = '0;
  logic          tvalid_o;
  logic [1:0][DW-1:0] tdata_o;

  always #5 clk = ~clk;

  nco #(
    .IQ_NUM         (2),
    .DATA_WIDTH     (DW),
    .PHASE_WIDTH    (PW),
    .LUT_ADDR_WIDTH (AW)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn_i),
    .en_i           (en_i),
    .tvalid_i       (tvalid_i),
    .phase_inc_i    (phase_inc_i),
    .phase_offset_i (phase_offset_i),
    .tvalid_o       (tvalid_o),
    .tdata_o        (tdata_o)
  );

  // ---------------- Scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [PW-1:0] m_acc = '0;
  logic [31:0]   en_cyc = '0;
  logic          last_en = 1'b0;
  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_i = '0;
  logic [DW-1:0] hold_q = '0;
  logic [W-1:0]  mon_e;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  // Ideal model: the top AW+2 phase bits select a point half a step into
  // the corresponding slot of the full circle.
  function automatic void model(input logic [PW-1:0] ph, output int ei,
                                output int eq);
    real ang;
    int  n;
    n   = int'(ph[PW-1 -: AW+2]);
    ang = (2.0 * $itor(n) + 1.0) * PI / $itor(1 << (AW + 2));
    ei  = rnd(32767.0 * $cos(ang));
    eq  = rnd(32767.0 * $sin(ang));
  endfunction

  // Count enabled edges; outputs of the sample accepted on enabled edge E
  // appear after enabled edge E+3.
  always @(posedge clk) begin
    last_en = en_i;
    if (en_i) en_cyc = en_cyc + 1;
  end

  always @(negedge clk) begin
    if (rstn_i) begin
      if (last_en) begin
        if (exp_q.size() > 0 && exp_q[0][W-2 -: 32] + 32'd3 == en_cyc) begin
          mon_e = exp_q.pop_front();
          check("tvalid", tvalid_o, mon_e[W-1]);
          if (mon_e[W-1]) begin
            check("I", $signed(tdata_o[0]), $signed(mon_e[2*DW-1:DW]));
            check("Q", $signed(tdata_o[1]), $signed(mon_e[DW-1:0]));
          end
          hold_v = mon_e[W-1];
          hold_i = mon_e[2*DW-1:DW];
          hold_q = mon_e[DW-1:0];
        end else begin
          check("tvalid_fill", tvalid_o, 0);
          hold_v = 1'b0;
        end
      end else begin
        check("stall_tvalid", tvalid_o, hold_v);
        if (hold_v) begin
          check("stall_I", $signed(tdata_o[0]), $signed(hold_i));
          check("stall_Q", $signed(tdata_o[1]), $signed(hold_q));
        end
      end
    end
  end

  // ---------------- Driver tasks ----------------
  // One call = one clock cycle; entered and left at posedge + 1.
  task automatic step(input logic en, input logic vld, input logic [PW-1:0] inc,
                      input logic [PW-1:0] off, input int ei, input int eq);
    logic [31:0] iss;
    en_i = en;
    tvalid_i = vld;
    phase_inc_i = inc;
    phase_offset_i = off;
    if (en) begin
      iss = en_cyc + 32'd1;
      exp_q.push_back({vld, iss, DW'(ei), DW'(eq)});
      if (vld) m_acc = m_acc + inc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step_model(input logic en, input logic vld,
                            input logic [PW-1:0] inc, input logic [PW-1:0] off);
    int ei;
    int eq;
    model(m_acc + off, ei, eq);
    step(en, vld, inc, off, ei, eq);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    en_i = 1'b0;
    tvalid_i = 1'b0;
    #1;
    check("rst_tvalid", tvalid_o, 0);
    check("rst_I", $signed(tdata_o[0]), 0);
    check("rst_Q", $signed(tdata_o[1]), 0);
    exp_q.delete();
    m_acc = '0;
    hold_v = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn_i = 1'b1;
  endtask

  // ---------------- Stimulus ----------------
  int ti[4] = '{32767, -25, -32767, 25};
  int tq[4] = '{25, 32767, -25, -32767};
  logic [PW-1:0] r_inc;
  logic [PW-1:0] r_off;
  int n_left;

  initial begin
    #2;
    do_reset();

    // DC: phase 0 every sample.
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, '0, '0, 32767, 25);

    // Quarter-rate with a 3-cycle stall and a 1-cycle bubble mid-stream.
    for (int k = 0; k < 12; k++) begin
      if (k == 4) for (int s = 0; s < 3; s++) step(1'b0, 1'b1, 32'h4000_0000, '0, 0, 0);
      if (k == 6) step(1'b1, 1'b0, 32'h4000_0000, '0, 0, 0);
      step(1'b1, 1'b1, 32'h4000_0000, '0, ti[k % 4], tq[k % 4]);
    end

    // Nyquist: alternating full-scale values, negation must not overflow.
    for (int k = 0; k < 6; k++)
      step(1'b1, 1'b1, 32'h8000_0000, '0, ti[(k % 2) * 2], tq[(k % 2) * 2]);

    // Random frequency/offset words with random enable and valid gaps.
    r_inc = '0;
    r_off = '0;
    for (int k = 0; k < 1500; k++) begin
      if (k % 64 == 0) begin
        r_inc = $urandom();
        r_off = $urandom();
      end
      step_model($urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0, r_inc, r_off);
    end

    // Asynchronous reset with the pipeline busy, then restart at phase = offset.
    do_reset();
    for (int k = 0; k < 6; k++)
      step(1'b1, 1'b1, 32'h4000_0000, 32'h4000_0000, ti[(k + 1) % 4], tq[(k + 1) % 4]);

    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, '0, '0, 0, 0);

    n_left = 0;
    foreach (exp_q[i]) if (exp_q[i][W-1]) n_left++;
    check("drain_valid_left", n_left, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
